// File: rtl/oddr_dqs_pkg.sv
`default_nettype none
// ============================================================================
// oddr_dqs_pkg : shared types and helpers for the DQS burst serializer
// Rev 1.0
// ============================================================================
package oddr_dqs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        BURST = 2'd2,
        POST  = 2'd3
    } state_e;

    localparam logic DQS_PRE_LVL  = 1'b0;
    localparam logic DQS_POST_LVL = 1'b0;

    // Minimum of one bit so a counter never collapses to zero width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oddr_lane_shifter.sv
`default_nettype none
// ============================================================================
// oddr_lane_shifter : one DQ lane, RATIO-bit load/shift-right register
// Rev 1.0
// ============================================================================
module oddr_lane_shifter #(
    parameter int RATIO = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [RATIO-1:0] din_i,
    output logic             q_o
);

    logic [RATIO-1:0] sh_q;
    logic [RATIO-1:0] sh_d;

    // Zeros shift in so the lane returns to 0 once the last beat has left.
    always_comb begin
        sh_d = {1'b0, sh_q[RATIO-1:1]};
        if (load_i) begin
            sh_d = din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_o = sh_q[0];

endmodule
`default_nettype wire

// File: rtl/oddr_dqs_burst_serializer.sv
`default_nettype none
// ============================================================================
// oddr_dqs_burst_serializer : word-to-DQ-lane serializer with DQS framing
// Rev 1.0
// ============================================================================
module oddr_dqs_burst_serializer
    import oddr_dqs_pkg::*;
#(
    parameter int    DATA_WIDTH    = 8,
    parameter int    RATIO         = 4,
    parameter int    PREAMBLE_CYC  = 1,
    parameter int    POSTAMBLE_CYC = 1,
    parameter string MEMMODE       = "ENABLED"
) (
    input  logic                        SCLK,
    input  logic                        RST,
    input  logic [DATA_WIDTH*RATIO-1:0] DIN,
    input  logic                        DIN_VALID,
    input  logic                        DIN_LAST,
    output logic                        DIN_READY,
    output logic [DATA_WIDTH-1:0]       Q,
    output logic                        DQ_OE,
    output logic                        DQS,
    output logic                        DQS_OE,
    output logic                        BUSY,
    output logic                        UNDERRUN
);

    localparam bit   MODE_EN = (MEMMODE == "ENABLED");
    localparam int   MAX_CNT = (RATIO > 4) ? RATIO : 4;
    localparam int   CNT_W   = clog2(MAX_CNT);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(PREAMBLE_CYC - 1);
    localparam logic [CNT_W-1:0] POST_END  = CNT_W'(POSTAMBLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if ((RATIO < 2) || ((RATIO % 2) != 0)) begin : g_bad_ratio
        $error("RATIO must be even and >= 2");
    end
    if ((PREAMBLE_CYC < 1) || (PREAMBLE_CYC > 4)) begin : g_bad_pre
        $error("PREAMBLE_CYC must be 1..4");
    end
    if ((POSTAMBLE_CYC < 1) || (POSTAMBLE_CYC > 4)) begin : g_bad_post
        $error("POSTAMBLE_CYC must be 1..4");
    end
    if ((MEMMODE != "ENABLED") && (MEMMODE != "DISABLED")) begin : g_bad_mode
        $error("MEMMODE must be ENABLED or DISABLED");
    end

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH*RATIO-1:0] word_q, word_d;
    logic                        last_q, last_d;
    logic                        ready_q, ready_d;
    logic                        underrun_q, underrun_d;
    logic                        dq_oe_q, dq_oe_d;
    logic                        dqs_q, dqs_d;
    logic                        dqs_oe_q, dqs_oe_d;
    logic                        busy_q, busy_d;
    logic                        accept;
    logic                        shift_load;
    logic [DATA_WIDTH-1:0]       lane_q;

    always_comb begin
        accept     = DIN_VALID & ready_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = DIN;
                    last_d  = DIN_LAST;
                    cnt_d   = '0;
                    state_d = MODE_EN ? PRE : BURST;
                end
            end
            PRE: begin
                if (cnt_q == PRE_END) begin
                    cnt_d   = '0;
                    state_d = BURST;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            BURST: begin
                if (cnt_q == LAST_BEAT) begin
                    cnt_d = '0;
                    if (accept) begin
                        word_d = DIN;
                        last_d = DIN_LAST;
                    end else begin
                        state_d    = MODE_EN ? POST : IDLE;
                        underrun_d = ~last_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            POST: begin
                if (cnt_q == POST_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // READY looks at the next state so the handshake never lags the FSM.
        ready_d = (state_d == IDLE) |
                  ((state_d == BURST) & (cnt_d == LAST_BEAT) & ~last_d);
    end

    // Pad-side framing trails the FSM by one register stage, matching the lanes.
    always_comb begin
        busy_d   = (state_q != IDLE);
        dq_oe_d  = (state_q == BURST);
        dqs_oe_d = MODE_EN && (state_q != IDLE);
        dqs_d    = 1'b0;
        case (state_q)
            PRE:     dqs_d = DQS_PRE_LVL;
            BURST:   dqs_d = ~cnt_q[0];
            POST:    dqs_d = DQS_POST_LVL;
            default: dqs_d = 1'b0;
        endcase
        dqs_d = dqs_d & MODE_EN;
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            ready_q    <= 1'b1;
            underrun_q <= 1'b0;
            dq_oe_q    <= 1'b0;
            dqs_q      <= 1'b0;
            dqs_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            last_q     <= last_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            dq_oe_q    <= dq_oe_d;
            dqs_q      <= dqs_d;
            dqs_oe_q   <= dqs_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign shift_load = (state_q == BURST) && (cnt_q == '0);

    for (genvar l = 0; l < DATA_WIDTH; l++) begin : g_lane
        oddr_lane_shifter #(
            .RATIO (RATIO)
        ) u_shifter (
            .clk_i  (SCLK),
            .rst_i  (RST),
            .load_i (shift_load),
            .din_i  (word_q[l*RATIO +: RATIO]),
            .q_o    (lane_q[l])
        );
    end

    assign DIN_READY = ready_q;
    assign Q         = lane_q;
    assign DQ_OE     = dq_oe_q;
    assign DQS       = dqs_q;
    assign DQS_OE    = dqs_oe_q;
    assign BUSY      = busy_q;
    assign UNDERRUN  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_oddr_dqs_burst_serializer.sv
`default_nettype none
// ============================================================================
// tb_oddr_dqs_burst_serializer : directed self-checking bench, three configs
// Rev 1.0
// ============================================================================
module tb_oddr_dqs_burst_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Config A: defaults
    logic        rst_a, valid_a, last_a, rdy_a, dqoe_a, dqs_a, dqsoe_a, busy_a, un_a;
    logic [31:0] din_a;
    logic [7:0]  q_a;
    // Config B: DISABLED, RATIO=2, DATA_WIDTH=4
    logic        rst_b, valid_b, last_b, rdy_b, dqoe_b, dqs_b, dqsoe_b, busy_b, un_b;
    logic [7:0]  din_b;
    logic [3:0]  q_b;
    // Config C: PREAMBLE_CYC=3, POSTAMBLE_CYC=2
    logic        rst_c, valid_c, last_c, rdy_c, dqoe_c, dqs_c, dqsoe_c, busy_c, un_c;
    logic [31:0] din_c;
    logic [7:0]  q_c;

    oddr_dqs_burst_serializer u_dut_a (
        .SCLK(clk), .RST(rst_a), .DIN(din_a), .DIN_VALID(valid_a), .DIN_LAST(last_a),
        .DIN_READY(rdy_a), .Q(q_a), .DQ_OE(dqoe_a), .DQS(dqs_a), .DQS_OE(dqsoe_a),
        .BUSY(busy_a), .UNDERRUN(un_a)
    );

    oddr_dqs_burst_serializer #(
        .DATA_WIDTH(4), .RATIO(2), .MEMMODE("DISABLED")
    ) u_dut_b (
        .SCLK(clk), .RST(rst_b), .DIN(din_b), .DIN_VALID(valid_b), .DIN_LAST(last_b),
        .DIN_READY(rdy_b), .Q(q_b), .DQ_OE(dqoe_b), .DQS(dqs_b), .DQS_OE(dqsoe_b),
        .BUSY(busy_b), .UNDERRUN(un_b)
    );

    oddr_dqs_burst_serializer #(
        .PREAMBLE_CYC(3), .POSTAMBLE_CYC(2)
    ) u_dut_c (
        .SCLK(clk), .RST(rst_c), .DIN(din_c), .DIN_VALID(valid_c), .DIN_LAST(last_c),
        .DIN_READY(rdy_c), .Q(q_c), .DQ_OE(dqoe_c), .DQS(dqs_c), .DQS_OE(dqsoe_c),
        .BUSY(busy_c), .UNDERRUN(un_c)
    );

    // Packed observation order everywhere: {BUSY, READY, DQS_OE, DQS, DQ_OE, UNDERRUN, Q}

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy_a, rdy_a, dqsoe_a, dqs_a, dqoe_a, un_a, q_a} !== {6'b010000, 8'h00}) begin
            fails++;
            $display("FAIL reset_a got %h exp %h", {busy_a, rdy_a, dqsoe_a, dqs_a, dqoe_a, un_a, q_a}, {6'b010000, 8'h00});
        end
        tests++;
        if ({busy_b, rdy_b, dqsoe_b, dqs_b, dqoe_b, un_b, q_b} !== {6'b010000, 4'h0}) begin
            fails++;
            $display("FAIL reset_b got %h exp %h", {busy_b, rdy_b, dqsoe_b, dqs_b, dqoe_b, un_b, q_b}, {6'b010000, 4'h0});
        end
        tests++;
        if ({busy_c, rdy_c, dqsoe_c, dqs_c, dqoe_c, un_c, q_c} !== {6'b010000, 8'h00}) begin
            fails++;
            $display("FAIL reset_c got %h exp %h", {busy_c, rdy_c, dqsoe_c, dqs_c, dqoe_c, un_c, q_c}, {6'b010000, 8'h00});
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    endtask

    task automatic test_single_word();
        logic [13:0] expt [8];
        logic [13:0] obs;
        expt = '{{6'b000000, 8'h00}, {6'b101000, 8'h00}, {6'b101110, 8'h01}, {6'b101010, 8'h02},
                 {6'b101110, 8'h01}, {6'b101010, 8'h02}, {6'b111000, 8'h00}, {6'b010000, 8'h00}};
        @(negedge clk);
        tests++;
        if (rdy_a !== 1'b1) begin
            fails++;
            $display("FAIL single_ready_idle got %b exp 1", rdy_a);
        end
        din_a = 32'h0000_00A5; last_a = 1'b1; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; last_a = 1'b0; din_a = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            obs = {busy_a, rdy_a, dqsoe_a, dqs_a, dqoe_a, un_a, q_a};
            tests++;
            if (obs !== expt[k]) begin
                fails++;
                $display("FAIL single_word k=%0d got %h exp %h", k, obs, expt[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        logic [7:0]  qexp [12];
        logic [13:0] obs;
        logic [13:0] expv;
        logic        acc;
        int          nacc;
        words = '{32'h0000_00A5, 32'hFFFF_0000, 32'h1234_5678};
        qexp  = '{8'h01, 8'h02, 8'h01, 8'h02, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
                  8'hAA, 8'h66, 8'h1E, 8'h01};
        @(negedge clk);
        din_a = words[0]; last_a = 1'b0; valid_a = 1'b1;
        @(posedge clk); #1;
        nacc  = 1;
        din_a = words[1];
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            obs        = {busy_a, rdy_a, dqsoe_a, dqs_a, dqoe_a, un_a, q_a};
            expv[13]   = (k >= 1 && k <= 14);
            expv[12]   = (k == 4 || k == 8 || k >= 14);
            expv[11]   = (k >= 1 && k <= 14);
            expv[10]   = (k >= 2 && k <= 13) && (k % 2 == 0);
            expv[9]    = (k >= 2 && k <= 13);
            expv[8]    = 1'b0;
            expv[7:0]  = (k >= 2 && k <= 13) ? qexp[k-2] : 8'h00;
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL back_to_back k=%0d got %h exp %h", k, obs, expv);
            end
            acc = valid_a & rdy_a;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc < 3) begin
                    din_a  = words[nacc];
                    last_a = (nacc == 2);
                end else begin
                    valid_a = 1'b0;
                    last_a  = 1'b0;
                end
            end
        end
        tests++;
        if (nacc !== 3) begin
            fails++;
            $display("FAIL back_to_back_accepts got %0d exp 3", nacc);
        end
    endtask

    task automatic test_underrun();
        logic exp_un;
        @(negedge clk);
        din_a = 32'h0000_00A5; last_a = 1'b0; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_un = (k == 5);
            tests++;
            if (un_a !== exp_un) begin
                fails++;
                $display("FAIL underrun_pulse k=%0d got %b exp %b", k, un_a, exp_un);
            end
            if (k == 4) begin
                tests++;
                if (rdy_a !== 1'b1) begin
                    fails++;
                    $display("FAIL underrun_ready_last_beat got %b exp 1", rdy_a);
                end
            end
            if (k == 6) begin
                tests++;
                if ({dqsoe_a, dqoe_a, q_a} !== {1'b1, 1'b0, 8'h00}) begin
                    fails++;
                    $display("FAIL underrun_post got %h exp %h", {dqsoe_a, dqoe_a, q_a}, {1'b1, 1'b0, 8'h00});
                end
            end
            if (k == 7) begin
                tests++;
                if ({busy_a, rdy_a} !== 2'b01) begin
                    fails++;
                    $display("FAIL underrun_idle got %b exp 01", {busy_a, rdy_a});
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [13:0] expt [8];
        logic [13:0] obs;
        expt = '{{6'b000000, 8'h00}, {6'b101000, 8'h00}, {6'b101110, 8'hAA}, {6'b101010, 8'h66},
                 {6'b101110, 8'h1E}, {6'b101010, 8'h01}, {6'b111000, 8'h00}, {6'b010000, 8'h00}};
        @(negedge clk);
        din_a = 32'h0000_00A5; last_a = 1'b1; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if ({dqoe_a, q_a} !== {1'b1, 8'h01}) begin
            fails++;
            $display("FAIL rst_mid_beat2 got %h exp %h", {dqoe_a, q_a}, {1'b1, 8'h01});
        end
        rst_a = 1'b1;
        @(negedge clk);
        obs = {busy_a, rdy_a, dqsoe_a, dqs_a, dqoe_a, un_a, q_a};
        tests++;
        if (obs !== {6'b010000, 8'h00}) begin
            fails++;
            $display("FAIL rst_mid_abort got %h exp %h", obs, {6'b010000, 8'h00});
        end
        rst_a = 1'b0;
        din_a = 32'h1234_5678; last_a = 1'b1; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            obs = {busy_a, rdy_a, dqsoe_a, dqs_a, dqoe_a, un_a, q_a};
            tests++;
            if (obs !== expt[k]) begin
                fails++;
                $display("FAIL rst_mid_resume k=%0d got %h exp %h", k, obs, expt[k]);
            end
        end
    endtask

    task automatic test_disabled_mode();
        logic [9:0] expt [5];
        logic [9:0] obs;
        expt = '{{6'b000000, 4'h0}, {6'b100010, 4'h6}, {6'b110010, 4'hC},
                 {6'b010000, 4'h0}, {6'b010000, 4'h0}};
        @(negedge clk);
        tests++;
        if (rdy_b !== 1'b1) begin
            fails++;
            $display("FAIL disabled_ready_idle got %b exp 1", rdy_b);
        end
        din_b = 8'hB4; last_b = 1'b1; valid_b = 1'b1;
        @(posedge clk); #1;
        valid_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            obs = {busy_b, rdy_b, dqsoe_b, dqs_b, dqoe_b, un_b, q_b};
            tests++;
            if (obs !== expt[k]) begin
                fails++;
                $display("FAIL disabled_mode k=%0d got %h exp %h", k, obs, expt[k]);
            end
        end
    endtask

    task automatic test_long_framing();
        logic [13:0] expt [12];
        logic [13:0] obs;
        logic        acc;
        int          nacc;
        int          kacc;
        expt = '{{6'b000000, 8'h00}, {6'b101000, 8'h00}, {6'b101000, 8'h00}, {6'b101000, 8'h00},
                 {6'b101110, 8'h01}, {6'b101010, 8'h02}, {6'b101110, 8'h01}, {6'b101010, 8'h02},
                 {6'b101000, 8'h00}, {6'b111000, 8'h00}, {6'b000000, 8'h00}, {6'b101000, 8'h00}};
        nacc = 0;
        kacc = -1;
        @(negedge clk);
        din_c = 32'h0000_00A5; last_c = 1'b1; valid_c = 1'b1;
        @(posedge clk); #1;
        din_c = 32'h1234_5678;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            obs = {busy_c, rdy_c, dqsoe_c, dqs_c, dqoe_c, un_c, q_c};
            tests++;
            if (obs !== expt[k]) begin
                fails++;
                $display("FAIL long_framing k=%0d got %h exp %h", k, obs, expt[k]);
            end
            acc = valid_c & rdy_c;
            if (acc) begin
                nacc++;
                kacc = k;
            end
            @(posedge clk); #1;
            if (acc) valid_c = 1'b0;
        end
        tests++;
        if (nacc !== 1 || kacc !== 9) begin
            fails++;
            $display("FAIL long_framing_holdoff got n=%0d k=%0d exp n=1 k=9", nacc, kacc);
        end
        repeat (16) @(posedge clk);
    endtask

    initial begin
        rst_a = 1'b1; valid_a = 1'b0; last_a = 1'b0; din_a = '0;
        rst_b = 1'b1; valid_b = 1'b0; last_b = 1'b0; din_b = '0;
        rst_c = 1'b1; valid_c = 1'b0; last_c = 1'b0; din_c = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_reset_mid_burst();
        test_disabled_mode();
        test_long_framing();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
